// File: rtl/axi_rd_burst_split_pkg.sv
// Shared constants and types for the AXI read burst splitter.
package axi_rd_burst_split_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  // SLVERR and DECERR both carry bit 1 set
  function automatic logic is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_rd_burst_split_if.sv
// AXI4 read channel bundle (AR + R) with master and slave views.
interface axi_rd_burst_split_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arprot, arvalid, rready,
    input  arready, rdata, rid, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arprot, arvalid, rready,
    output arready, rdata, rid, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_burst_split_addr_next.sv
// axi_burst_addr_next: address of the following beat of an AXI burst.
// Purely combinational; WRAP with an illegal length falls back to INCR.
module axi_burst_addr_next
  import axi_rd_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_ok;

  // Select the next address from the burst type
  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    incr_addr = addr + bytes;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end
endmodule

// File: rtl/axi_rd_burst_split.sv
// axi_rd_burst_split: splits each upstream AXI4 read burst into serial
// single-beat downstream reads, one burst outstanding at a time.
// Optional macro AXI_RD_SPLIT_ERR_ABORT_EN: after an error response, the
// remaining beats are not issued and return zero data with that error code.
module axi_rd_burst_split
  import axi_rd_burst_split_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                 s_clk,
  input  logic                 s_rst,
  axi_rd_burst_split_if.slave  s_axi,
  axi_rd_burst_split_if.master m_axi
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [2:0]            prot_q, prot_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
  logic                  err_q, err_d;
`endif
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  is_last;

  axi_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_next (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign is_last = (cnt_q == len_q);

  // State and burst context registers
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: capture burst, issue beat, wait for data, return beat
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
        err_d = 1'b0;
`endif
        if (s_axi.arvalid) begin
          addr_d  = s_axi.araddr;
          id_d    = s_axi.arid;
          len_d   = s_axi.arlen;
          size_d  = s_axi.arsize;
          burst_d = s_axi.arburst;
          prot_d  = s_axi.arprot;
          cnt_d   = 8'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axi.arready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          rresp_d = m_axi.rresp;
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
          if (is_err(m_axi.rresp)) err_d = 1'b1;
`endif
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (s_axi.rready) begin
          if (is_last) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = next_addr;
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_ISSUE;
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
            // Burst already failed: synthesize the remaining beats locally
            if (err_q) begin
              rdata_d = '0;
              state_d = ST_SEND;
            end
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every valid/ready is a decode of the registered state
  assign s_axi.arready = (state_q == ST_IDLE);
  assign s_axi.rvalid  = (state_q == ST_SEND);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rid     = id_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = (state_q == ST_SEND) && is_last;

  assign m_axi.arvalid = (state_q == ST_ISSUE);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arid    = id_q;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = (state_q == ST_ISSUE) ? BURST_INCR : BURST_FIXED;
  assign m_axi.arprot  = prot_q;
  assign m_axi.rready  = (state_q == ST_WAIT);
endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Directed bench for axi_rd_burst_split; expectations follow
// AXI_RD_SPLIT_ERR_ABORT_EN when the bench is built with it defined.
module tb_axi_rd_burst_split;
  import axi_rd_burst_split_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  always #5 s_clk = ~s_clk;

  axi_rd_burst_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s_axi ();
  axi_rd_burst_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_axi ();

  axi_rd_burst_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .s_axi (s_axi),
    .m_axi (m_axi)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ar_addr_log [256];
  logic [7:0]  ar_len_log  [256];
  logic [3:0]  ar_id_log   [256];
  logic [1:0]  ar_burst_log[256];
  int          ar_cnt = 0;
  int          burst_base = 0;
  int          r_delay = 0;
  logic [1:0]  resp_plan [16];
  logic [31:0] exp_addr  [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream responder: accepts every AR, returns one beat per AR after r_delay cycles
  initial begin : responder
    logic ar_fire, r_fire, rst_seen, pend;
    int   dly, idx;
    m_axi.arready = 1'b1;
    m_axi.rvalid  = 1'b0;
    m_axi.rdata   = '0;
    m_axi.rresp   = RESP_OKAY;
    m_axi.rid     = 4'hA;
    m_axi.rlast   = 1'b1;
    pend = 1'b0;
    dly  = 0;
    idx  = 0;
    forever begin
      @(negedge s_clk);
      ar_fire  = m_axi.arvalid && m_axi.arready;
      r_fire   = m_axi.rvalid && m_axi.rready;
      rst_seen = s_rst;
      if (ar_fire) begin
        idx = ar_cnt;
        ar_addr_log[idx & 255]  = m_axi.araddr;
        ar_len_log[idx & 255]   = m_axi.arlen;
        ar_id_log[idx & 255]    = m_axi.arid;
        ar_burst_log[idx & 255] = m_axi.arburst;
        ar_cnt++;
      end
      @(posedge s_clk);
      #1;
      if (rst_seen) begin
        pend = 1'b0;
        m_axi.rvalid = 1'b0;
      end else begin
        if (r_fire) m_axi.rvalid = 1'b0;
        if (ar_fire) begin
          pend = 1'b1;
          dly  = r_delay;
          m_axi.rdata = 32'hD000_0000 + 32'(idx);
          m_axi.rresp = resp_plan[(idx - burst_base) & 15];
        end
        if (pend && !m_axi.rvalid) begin
          if (dly == 0) begin
            m_axi.rvalid = 1'b1;
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
      end
    end
  end

  task automatic set_exp(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
    exp_addr[0] = a0; exp_addr[1] = a1; exp_addr[2] = a2; exp_addr[3] = a3;
  endtask

  task automatic set_plan(input logic [1:0] p0, input logic [1:0] p1,
                          input logic [1:0] p2, input logic [1:0] p3);
    for (int i = 0; i < 16; i++) resp_plan[i] = RESP_OKAY;
    resp_plan[0] = p0; resp_plan[1] = p1; resp_plan[2] = p2; resp_plan[3] = p3;
  endtask

  // Called at a negedge with the DUT idle: present one AR for one cycle
  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_axi.araddr  = addr;
    s_axi.arid    = id;
    s_axi.arlen   = len;
    s_axi.arsize  = size;
    s_axi.arburst = burst;
    s_axi.arprot  = 3'b010;
    s_axi.arvalid = 1'b1;
    @(posedge s_clk);
    #1 s_axi.arvalid = 1'b0;
  endtask

  task automatic run_burst(input string name, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int n_ar, input int stall_beat, input int stall_cyc);
    int          base, n;
    logic        ab;
    logic [1:0]  ab_resp, exp_resp;
    logic [31:0] exp_data, held;
    base = ar_cnt;
    burst_base = base;
    ab = 1'b0;
    ab_resp = RESP_OKAY;
    @(negedge s_clk);
    chk({name, "_arready_idle"}, 64'(s_axi.arready), 64'd1);
    send_ar(addr, id, len, size, burst);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      @(negedge s_clk);
      while (!s_axi.rvalid && n < 100) begin
        @(negedge s_clk);
        n++;
      end
      if (!s_axi.rvalid) begin
        chk({name, "_beat_timeout"}, 64'd0, 64'd1);
        return;
      end
      if (ab) begin
        exp_data = 32'd0;
        exp_resp = ab_resp;
      end else begin
        exp_data = 32'hD000_0000 + 32'(base + b);
        exp_resp = resp_plan[b];
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
        if (is_err(exp_resp)) begin
          ab = 1'b1;
          ab_resp = exp_resp;
        end
`endif
      end
      chk({name, "_rdata"}, 64'(s_axi.rdata), 64'(exp_data));
      chk({name, "_rresp"}, 64'(s_axi.rresp), 64'(exp_resp));
      chk({name, "_rid"}, 64'(s_axi.rid), 64'(id));
      chk({name, "_rlast"}, 64'(s_axi.rlast), 64'(b == int'(len)));
      chk({name, "_arready_busy"}, 64'(s_axi.arready), 64'd0);
      $display("%s beat %0d: rdata=0x%08h rresp=%0d rid=%0d rlast=%0b",
               name, b, s_axi.rdata, s_axi.rresp, s_axi.rid, s_axi.rlast);
      if (b == stall_beat) begin
        held = s_axi.rdata;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge s_clk);
          chk({name, "_stall_rvalid"}, 64'(s_axi.rvalid), 64'd1);
          chk({name, "_stall_rdata"}, 64'(s_axi.rdata), 64'(held));
          chk({name, "_stall_m_arvalid"}, 64'(m_axi.arvalid), 64'd0);
        end
      end
      s_axi.rready = 1'b1;
      @(posedge s_clk);
      #1 s_axi.rready = 1'b0;
    end
    repeat (3) @(negedge s_clk);
    chk({name, "_ar_count"}, 64'(ar_cnt - base), 64'(n_ar));
    for (int i = 0; i < n_ar; i++) begin
      chk({name, "_m_araddr"}, 64'(ar_addr_log[(base + i) & 255]), 64'(exp_addr[i]));
      chk({name, "_m_arlen"}, 64'(ar_len_log[(base + i) & 255]), 64'd0);
      chk({name, "_m_arid"}, 64'(ar_id_log[(base + i) & 255]), 64'(id));
      chk({name, "_m_arburst"}, 64'(ar_burst_log[(base + i) & 255]), 64'(BURST_INCR));
    end
  endtask

  initial begin : main
    int n;
    s_axi.araddr = '0; s_axi.arid = '0; s_axi.arlen = '0; s_axi.arsize = '0;
    s_axi.arburst = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    set_plan(RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY);
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    chk("rst_arready", 64'(s_axi.arready), 64'd1);
    chk("rst_rvalid", 64'(s_axi.rvalid), 64'd0);
    chk("rst_rlast", 64'(s_axi.rlast), 64'd0);
    chk("rst_rdata", 64'(s_axi.rdata), 64'd0);
    chk("rst_rid", 64'(s_axi.rid), 64'd0);
    chk("rst_m_arvalid", 64'(m_axi.arvalid), 64'd0);
    chk("rst_m_rready", 64'(m_axi.rready), 64'd0);
    chk("rst_m_araddr", 64'(m_axi.araddr), 64'd0);
    chk("rst_m_arburst", 64'(m_axi.arburst), 64'd0);
    s_rst = 1'b0;

    set_exp(32'h1000, 32'h1004, 32'h1008, 32'h100C);
    run_burst("incr", 32'h1000, 4'd3, 8'd3, 3'd2, BURST_INCR, 4, -1, 0);

    set_exp(32'h1038, 32'h1020, 32'h1028, 32'h1030);
    run_burst("wrap", 32'h1038, 4'd5, 8'd3, 3'd3, BURST_WRAP, 4, -1, 0);

    set_exp(32'h6008, 32'h600C, 32'h6010, 32'h0);
    run_burst("wrap_len2", 32'h6008, 4'd4, 8'd2, 3'd2, BURST_WRAP, 3, -1, 0);

    set_exp(32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 32'h0);
    run_burst("incr_rollover", 32'hFFFF_FFFC, 4'd9, 8'd1, 3'd2, BURST_INCR, 2, -1, 0);

    set_exp(32'h3000, 32'h3004, 32'h0, 32'h0);
    run_burst("stall", 32'h3000, 4'd6, 8'd1, 3'd2, BURST_INCR, 2, 1, 10);

    // Reset while the DUT waits for downstream data
    r_delay = 4;
    burst_base = ar_cnt;
    @(negedge s_clk);
    send_ar(32'h7000, 4'd8, 8'd3, 3'd2, BURST_INCR);
    n = 0;
    @(negedge s_clk);
    while (!m_axi.rready && n < 50) begin
      @(negedge s_clk);
      n++;
    end
    chk("rstmid_reached_wait", 64'(m_axi.rready), 64'd1);
    @(posedge s_clk);
    #1 s_rst = 1'b1;
    @(posedge s_clk);
    #1 s_rst = 1'b0;
    @(negedge s_clk);
    chk("rstmid_arready", 64'(s_axi.arready), 64'd1);
    chk("rstmid_rvalid", 64'(s_axi.rvalid), 64'd0);
    chk("rstmid_m_arvalid", 64'(m_axi.arvalid), 64'd0);
    chk("rstmid_m_rready", 64'(m_axi.rready), 64'd0);
    r_delay = 0;
    set_exp(32'h4000, 32'h0, 32'h0, 32'h0);
    run_burst("after_rst_len0", 32'h4000, 4'd2, 8'd0, 3'd2, BURST_INCR, 1, -1, 0);

    set_plan(RESP_OKAY, RESP_SLVERR, RESP_OKAY, RESP_EXOKAY);
    set_exp(32'h5000, 32'h5004, 32'h5008, 32'h500C);
`ifdef AXI_RD_SPLIT_ERR_ABORT_EN
    run_burst("err", 32'h5000, 4'd7, 8'd3, 3'd2, BURST_INCR, 2, -1, 0);
`else
    run_burst("err", 32'h5000, 4'd7, 8'd3, 3'd2, BURST_INCR, 4, -1, 0);
`endif

    set_plan(RESP_EXOKAY, RESP_OKAY, RESP_EXOKAY, RESP_OKAY);
    set_exp(32'h2000, 32'h2000, 32'h2000, 32'h0);
    run_burst("fixed", 32'h2000, 4'd1, 8'd2, 3'd2, BURST_FIXED, 3, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
